// File: rtl/rr_grant_index_arbiter.sv
// rr_grant_index_arbiter: 16-way round-robin arbiter with a registered winner
// index and valid flag; each grant ends on ack, withdrawal or hold timeout.
module rr_grant_index_arbiter #(
  parameter int N_REQ    = 16,
  parameter int IDX_W    = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             gnt_ack,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             timeout,
  output logic             busy
);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t           r_state;
  state_t           w_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_ptr;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx;
  logic [7:0]       r_hold;
  logic [7:0]       w_hold;
  logic             r_vld;
  logic             w_vld;
  logic             r_to;
  logic             w_to;
  logic [IDX_W-1:0] w_win;
  logic             w_win_vld;
  logic             w_release;

  // Scan from the farthest offset down so the nearest request to ptr wins.
  always_comb begin
    w_win     = r_ptr;
    w_win_vld = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[r_ptr + IDX_W'(i)]) begin
        w_win     = r_ptr + IDX_W'(i);
        w_win_vld = 1'b1;
      end
    end
  end

  assign w_release = gnt_ack || !req[r_idx];

  always_comb begin
    w_state = r_state;
    w_ptr   = r_ptr;
    w_idx   = r_idx;
    w_hold  = r_hold;
    w_vld   = r_vld;
    w_to    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_win_vld) begin
          w_idx   = w_win;
          w_vld   = 1'b1;
          w_hold  = 8'd0;
          w_state = S_GRANT;
        end
      end
      S_GRANT: begin
        if (w_release || r_hold == HOLD_LAST) begin
          w_to    = !w_release;
          w_vld   = 1'b0;
          w_ptr   = r_idx + IDX_W'(1);
          w_state = S_IDLE;
        end else begin
          w_hold = r_hold + 8'd1;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_hold  <= 8'd0;
      r_vld   <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_ptr   <= w_ptr;
      r_idx   <= w_idx;
      r_hold  <= w_hold;
      r_vld   <= w_vld;
      r_to    <= w_to;
    end
  end

  assign gnt_idx = r_idx;
  assign gnt_vld = r_vld;
  assign timeout = r_to;
  assign busy    = (r_state == S_GRANT);

endmodule

// File: tb/tb_rr_grant_index_arbiter.sv
// tb_rr_grant_index_arbiter: table-driven vectors through a scoreboard queue,
// plus hand-written reset and async-reset-mid-grant sequences.
module tb_rr_grant_index_arbiter;

  typedef struct {
    logic [15:0] req;
    logic        ack;
    logic        vld;
    logic [3:0]  idx;
    logic        to;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic        gnt_ack;
  logic [3:0]  gnt_idx;
  logic        gnt_vld;
  logic        timeout;
  logic        busy;

  int   n_tests;
  int   n_fail;
  vec_t vecs[$];
  vec_t exp_q[$];

  rr_grant_index_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt_ack (gnt_ack),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .timeout (timeout),
    .busy    (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [15:0] r, input logic a,
                     input logic v, input logic [3:0] i,
                     input logic t);
    vec_t e;
    e.req = r;
    e.ack = a;
    e.vld = v;
    e.idx = i;
    e.to  = t;
    vecs.push_back(e);
  endtask

  // Drive one cycle of inputs, queue its expectation, compare after the edge.
  task automatic step(input string tag, input vec_t v);
    vec_t e;
    req     = v.req;
    gnt_ack = v.ack;
    exp_q.push_back(v);
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check({tag, " sb_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check({tag, " vld"}, int'(gnt_vld), int'(e.vld));
      check({tag, " busy"}, int'(busy), int'(e.vld));
      check({tag, " to"}, int'(timeout), int'(e.to));
      if (e.vld)
        check({tag, " idx"}, int'(gnt_idx), int'(e.idx));
    end
  endtask

  task automatic step_h(input string tag, input logic [15:0] r,
                        input logic a, input logic v,
                        input logic [3:0] i, input logic t);
    vec_t e;
    e.req = r;
    e.ack = a;
    e.vld = v;
    e.idx = i;
    e.to  = t;
    step(tag, e);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // First grant after reset release
    add(16'hFFFF, 1'b0, 1'b1, 4'd0, 1'b0);
    // Rotation 1..15 then back to 0, one idle cycle per release
    for (int k = 1; k <= 16; k++) begin
      add(16'hFFFF, 1'b1, 1'b0, 4'd0, 1'b0);
      add(16'hFFFF, 1'b0, 1'b1, 4'(k), 1'b0);
    end
    // Wrap/priority from ptr=14
    add(16'h2000, 1'b0, 1'b0, 4'd0,  1'b0);
    add(16'h2000, 1'b0, 1'b1, 4'd13, 1'b0);
    add(16'h0009, 1'b1, 1'b0, 4'd0,  1'b0);
    add(16'h0009, 1'b0, 1'b1, 4'd0,  1'b0);
    add(16'h0009, 1'b1, 1'b0, 4'd0,  1'b0);
    add(16'h0009, 1'b0, 1'b1, 4'd3,  1'b0);
    add(16'h0009, 1'b1, 1'b0, 4'd0,  1'b0);
    add(16'h0009, 1'b0, 1'b1, 4'd0,  1'b0);
    // Timeout on idx 5: 8 cycles valid, 1-cycle pulse, regrant
    add(16'h0020, 1'b0, 1'b0, 4'd0, 1'b0);
    add(16'h0020, 1'b0, 1'b1, 4'd5, 1'b0);
    for (int k = 0; k < 7; k++)
      add(16'h0020, 1'b0, 1'b1, 4'd5, 1'b0);
    add(16'h0020, 1'b0, 1'b0, 4'd0, 1'b1);
    add(16'h0020, 1'b0, 1'b1, 4'd5, 1'b0);
    // Withdraw + ack together on idx 7, then 8; ack ignored in IDLE
    add(16'h0080, 1'b0, 1'b0, 4'd0, 1'b0);
    add(16'h0080, 1'b0, 1'b1, 4'd7, 1'b0);
    add(16'h0100, 1'b1, 1'b0, 4'd0, 1'b0);
    add(16'h0180, 1'b0, 1'b1, 4'd8, 1'b0);
    add(16'h0180, 1'b1, 1'b0, 4'd0, 1'b0);
    add(16'h0000, 1'b1, 1'b0, 4'd0, 1'b0);
    add(16'h0180, 1'b1, 1'b1, 4'd7, 1'b0);
    // Set up grant on idx 9 for the async reset sequence
    add(16'h0200, 1'b0, 1'b0, 4'd0, 1'b0);
    add(16'h0200, 1'b0, 1'b1, 4'd9, 1'b0);

    rst     = 1'b1;
    req     = 16'hFFFF;
    gnt_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst vld",  int'(gnt_vld), 0);
    check("rst idx",  int'(gnt_idx), 0);
    check("rst to",   int'(timeout), 0);
    check("rst busy", int'(busy),    0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      step($sformatf("vec%0d", i), vecs[i]);

    // Async reset between edges while granting idx 9
    #2;
    req = 16'h0201;
    rst = 1'b1;
    #1;
    check("arst vld",  int'(gnt_vld), 0);
    check("arst busy", int'(busy),    0);
    check("arst idx",  int'(gnt_idx), 0);
    #1;
    rst = 1'b0;
    @(negedge clk);
    step_h("arst g0",   16'h0201, 1'b0, 1'b1, 4'd0, 1'b0);
    step_h("arst rel",  16'h0201, 1'b1, 1'b0, 4'd0, 1'b0);
    step_h("arst g9",   16'h0201, 1'b0, 1'b1, 4'd9, 1'b0);

    check("sb drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
